// File: rtl/gshare_bp_pkg.sv
// Shared types and saturating-counter helpers for the gshare direction predictor.
package gshare_bp_pkg;

  typedef enum logic {BP_INIT, BP_RUN} bp_state_e;

  // Table write-port operation: init walker sets, resolution path increments/decrements.
  typedef enum logic [1:0] {WR_SET, WR_INC, WR_DEC} wr_op_e;

  localparam int unsigned CTR_MAX_W = 8;

  function automatic logic [CTR_MAX_W-1:0] sat_inc(input logic [CTR_MAX_W-1:0] c,
                                                   input int unsigned w);
    logic [CTR_MAX_W-1:0] top;
    top = CTR_MAX_W'((1 << w) - 1);
    return (c >= top) ? top : c + CTR_MAX_W'(1);
  endfunction

  function automatic logic [CTR_MAX_W-1:0] sat_dec(input logic [CTR_MAX_W-1:0] c);
    return (c == '0) ? '0 : c - CTR_MAX_W'(1);
  endfunction

endpackage

// File: rtl/gshare_bp_if.sv
// Fetch-side predict bundle and decode-side resolution bundle of the gshare predictor.
interface gshare_bp_if #(
  parameter int unsigned ADDR_WIDTH    = 26,
  parameter int unsigned INDEX_WIDTH   = 6,
  parameter int unsigned HISTORY_WIDTH = 6,
  parameter int unsigned STAT_WIDTH    = 32
);
  logic                     bp_ready;
  logic                     pred_req;
  logic [ADDR_WIDTH-1:0]    pred_pc;
  logic                     pred_taken;
  logic [INDEX_WIDTH-1:0]   pred_index;
  logic [HISTORY_WIDTH-1:0] pred_ghr;
  logic                     upd_valid;
  logic [INDEX_WIDTH-1:0]   upd_index;
  logic [HISTORY_WIDTH-1:0] upd_ghr;
  logic                     upd_taken;
  logic                     upd_mispredict;
  logic [STAT_WIDTH-1:0]    stat_branches;
  logic [STAT_WIDTH-1:0]    stat_mispred;

  modport master (
    output pred_req, pred_pc, upd_valid, upd_index, upd_ghr, upd_taken, upd_mispredict,
    input  bp_ready, pred_taken, pred_index, pred_ghr, stat_branches, stat_mispred
  );

  modport slave (
    input  pred_req, pred_pc, upd_valid, upd_index, upd_ghr, upd_taken, upd_mispredict,
    output bp_ready, pred_taken, pred_index, pred_ghr, stat_branches, stat_mispred
  );
endinterface

// File: rtl/gshare_bp_sat_counter_table.sv
// Saturating-counter storage: one combinational read port, one read-modify-write port.
// Left unreset so it can later be swapped for an SRAM; the init walker fills it instead.
module gshare_bp_sat_counter_table
  import gshare_bp_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH   = 6,
  parameter int unsigned COUNTER_WIDTH = 2
) (
  input  logic                     clk,
  input  logic [INDEX_WIDTH-1:0]   rd_idx_i,
  output logic [COUNTER_WIDTH-1:0] rd_dat_o,
  input  logic                     wr_en_i,
  input  wr_op_e                   wr_op_i,
  input  logic [INDEX_WIDTH-1:0]   wr_idx_i,
  input  logic [COUNTER_WIDTH-1:0] wr_dat_i
);
  localparam int unsigned DEPTH = 1 << INDEX_WIDTH;

  logic [COUNTER_WIDTH-1:0] mem_q [DEPTH];
  logic [COUNTER_WIDTH-1:0] wr_cur;
  logic [COUNTER_WIDTH-1:0] wr_new;

  assign rd_dat_o = mem_q[rd_idx_i];
  assign wr_cur   = mem_q[wr_idx_i];

  always_comb begin
    wr_new = wr_dat_i;
    unique case (wr_op_i)
      WR_INC:  wr_new = COUNTER_WIDTH'(sat_inc(CTR_MAX_W'(wr_cur), COUNTER_WIDTH));
      WR_DEC:  wr_new = COUNTER_WIDTH'(sat_dec(CTR_MAX_W'(wr_cur)));
      default: wr_new = wr_dat_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_new;
  end
endmodule

// File: rtl/gshare_bp.sv
// Gshare direction predictor: zero-cycle prediction from {PC xor speculative history}.
// Never stalls fetch; bp_ready stays low for 2^INDEX_WIDTH cycles after reset while the table fills.
module gshare_bp
  import gshare_bp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 26,
  parameter int unsigned INDEX_WIDTH   = 6,
  parameter int unsigned COUNTER_WIDTH = 2,
  parameter int unsigned HISTORY_WIDTH = 6,
  parameter int unsigned STAT_WIDTH    = 32
) (
  input logic       clk,
  input logic       rst_n,
  gshare_bp_if.slave bp
);
  localparam logic [COUNTER_WIDTH-1:0] WEAK_T   = COUNTER_WIDTH'(1 << (COUNTER_WIDTH - 1));
  localparam logic [INDEX_WIDTH-1:0]   LAST_IDX = '1;

  bp_state_e                state_q, state_d;
  logic [INDEX_WIDTH-1:0]   init_idx_q, init_idx_d;
  logic [HISTORY_WIDTH-1:0] ghr_q, ghr_d;
  logic [STAT_WIDTH-1:0]    stat_br_q, stat_br_d;
  logic [STAT_WIDTH-1:0]    stat_mp_q, stat_mp_d;

  logic                     run;
  logic [INDEX_WIDTH-1:0]   pred_idx;
  logic [COUNTER_WIDTH-1:0] rd_dat;
  logic                     pred_taken;
  logic                     wr_en;
  wr_op_e                   wr_op;
  logic [INDEX_WIDTH-1:0]   wr_idx;
  logic                     unused_pc_bits;

  assign run            = (state_q == BP_RUN);
  assign pred_idx       = bp.pred_pc[INDEX_WIDTH-1:0] ^ INDEX_WIDTH'(ghr_q);
  assign pred_taken     = run & rd_dat[COUNTER_WIDTH-1];
  assign unused_pc_bits = ^bp.pred_pc[ADDR_WIDTH-1:INDEX_WIDTH];

  // Single write port: the walker owns it in INIT, the resolution path in RUN.
  assign wr_en  = run ? bp.upd_valid : 1'b1;
  assign wr_idx = run ? bp.upd_index : init_idx_q;
  assign wr_op  = !run ? WR_SET : (bp.upd_taken ? WR_INC : WR_DEC);

  gshare_bp_sat_counter_table #(
    .INDEX_WIDTH  (INDEX_WIDTH),
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_table (
    .clk     (clk),
    .rd_idx_i(pred_idx),
    .rd_dat_o(rd_dat),
    .wr_en_i (wr_en),
    .wr_op_i (wr_op),
    .wr_idx_i(wr_idx),
    .wr_dat_i(WEAK_T)
  );

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    ghr_d      = ghr_q;
    stat_br_d  = stat_br_q;
    stat_mp_d  = stat_mp_q;
    unique case (state_q)
      BP_INIT: begin
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == LAST_IDX) state_d = BP_RUN;
      end
      BP_RUN: begin
        // Repair from the returned snapshot beats the speculative shift.
        if (bp.upd_valid && bp.upd_mispredict)
          ghr_d = HISTORY_WIDTH'({bp.upd_ghr, bp.upd_taken});
        else if (bp.pred_req)
          ghr_d = HISTORY_WIDTH'({ghr_q, pred_taken});
        if (bp.upd_valid) begin
          if (stat_br_q != '1) stat_br_d = stat_br_q + 1'b1;
          if (bp.upd_mispredict && stat_mp_q != '1) stat_mp_d = stat_mp_q + 1'b1;
        end
      end
      default: state_d = BP_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BP_INIT;
      init_idx_q <= '0;
      ghr_q      <= '0;
      stat_br_q  <= '0;
      stat_mp_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      ghr_q      <= ghr_d;
      stat_br_q  <= stat_br_d;
      stat_mp_q  <= stat_mp_d;
    end
  end

  assign bp.bp_ready      = run;
  assign bp.pred_taken    = pred_taken;
  assign bp.pred_index    = pred_idx;
  assign bp.pred_ghr      = ghr_q;
  assign bp.stat_branches = stat_br_q;
  assign bp.stat_mispred  = stat_mp_q;
endmodule
